// File: rtl/video_timing_rx_if.sv
// Parallel video input and recovered pixel/measurement outputs of video_timing_rx.
// The source drives the master side; the receiver sits on the slave side.
interface video_timing_rx_if #(
   parameter int unsigned CNT_W = 12
) ();
   logic             vid_hs;
   logic             vid_vs;
   logic             vid_de;
   logic [23:0]      vid_rgb;
   logic             pix_valid;
   logic [23:0]      pix_data;
   logic [CNT_W-1:0] pix_x;
   logic [CNT_W-1:0] pix_y;
   logic             sof;
   logic             eol;
   logic [CNT_W-1:0] meas_h_total;
   logic [CNT_W-1:0] meas_h_disp;
   logic [CNT_W-1:0] meas_v_total;
   logic [CNT_W-1:0] meas_v_disp;
   logic             locked;
   logic             timing_err;

   modport master (
      output vid_hs, vid_vs, vid_de, vid_rgb,
      input  pix_valid, pix_data, pix_x, pix_y, sof, eol,
      input  meas_h_total, meas_h_disp, meas_v_total, meas_v_disp, locked, timing_err
   );

   modport slave (
      input  vid_hs, vid_vs, vid_de, vid_rgb,
      output pix_valid, pix_data, pix_x, pix_y, sof, eol,
      output meas_h_total, meas_h_disp, meas_v_total, meas_v_disp, locked, timing_err
   );
endinterface

// File: rtl/video_timing_rx.sv
// Receive-side video timing recovery: pixel coordinates, sof/eol markers,
// line/frame timing measurement and lock detection for an hs/vs/de/rgb stream.
module video_timing_rx #(
   parameter int unsigned SYNC_POL    = 0,
   parameter int unsigned LOCK_FRAMES = 2,
   parameter int unsigned CNT_W       = 12
) (
   input logic              clk,
   input logic              rst_n,
   video_timing_rx_if.slave vid_if
);

   localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CntMax   = '1;
   localparam logic [CNT_W-1:0] CntMaxM1 = CntMax - CntOne;
   localparam logic [3:0]       LockCnt  = 4'(LOCK_FRAMES);

   typedef enum logic [1:0] {StSearch, StMeasure, StVerify, StLocked} state_e;

   // Input stage: syncs are normalised to active-high before registering
   logic             r_hs_a, r_vs_a, r_de1;
   logic [23:0]      r_rgb1;
   logic             r_hs2, r_vs2;
   logic             w_hs_start, w_vs_start;

   // Pixel path
   logic             r_pix_valid;
   logic [23:0]      r_pix_data;
   logic [CNT_W-1:0] r_pix_x, r_pix_y, r_row;
   logic             r_sof, r_eol;
   logic [CNT_W-1:0] w_x_nxt;

   // Line / frame measurement
   logic [CNT_W-1:0] r_hcnt, r_decnt, r_vcnt, r_actcnt;
   logic [CNT_W-1:0] r_line_total, r_line_disp;
   logic             r_tot_vld, r_disp_vld, r_frame_bad;
   logic [CNT_W-1:0] w_line_total;
   logic             w_de_line, w_line_bad;
   logic [CNT_W-1:0] w_t_htot, w_t_hdisp, w_t_vtot, w_t_vdisp;
   logic             w_t_bad, w_ovf, w_match;

   // Lock FSM
   state_e           r_state;
   logic [3:0]       r_match_cnt;
   logic [3:0]       w_cnt_inc;
   logic [CNT_W-1:0] r_meas_htot, r_meas_hdisp, r_meas_vtot, r_meas_vdisp;
   logic             r_locked, r_terr;

   assign w_hs_start = r_hs_a & ~r_hs2;
   assign w_vs_start = r_vs_a & ~r_vs2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hs_a <= 1'b0;
         r_vs_a <= 1'b0;
         r_de1  <= 1'b0;
         r_rgb1 <= '0;
         r_hs2  <= 1'b0;
         r_vs2  <= 1'b0;
      end else begin
         r_hs_a <= (SYNC_POL != 0) ? vid_if.vid_hs : ~vid_if.vid_hs;
         r_vs_a <= (SYNC_POL != 0) ? vid_if.vid_vs : ~vid_if.vid_vs;
         r_de1  <= vid_if.vid_de;
         r_rgb1 <= vid_if.vid_rgb;
         r_hs2  <= r_hs_a;
         r_vs2  <= r_vs_a;
      end
   end

   assign w_x_nxt = r_de1 ? (r_pix_valid ? r_pix_x + CntOne : '0) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pix_valid <= 1'b0;
         r_pix_data  <= '0;
         r_pix_x     <= '0;
         r_pix_y     <= '0;
         r_row       <= '0;
         r_sof       <= 1'b0;
         r_eol       <= 1'b0;
      end else begin
         r_pix_valid <= r_de1;
         r_pix_data  <= r_de1 ? r_rgb1 : '0;
         r_pix_x     <= w_x_nxt;
         r_pix_y     <= r_de1 ? r_row : '0;
         r_sof       <= r_de1 && (w_x_nxt == '0) && (r_row == '0);
         // vid_de is the de that will follow the pixel now leaving stage 1
         r_eol       <= r_de1 && !vid_if.vid_de;
         if (w_vs_start) begin
            r_row <= '0;
         end else if (r_pix_valid && !r_de1) begin
            r_row <= r_row + CntOne;
         end
      end
   end

   // Frame tuple as seen at this cycle: a coincident hs start closes its line first
   always_comb begin
      w_line_total = r_hcnt + CntOne;
      w_de_line    = (r_decnt != '0);
      w_line_bad   = w_hs_start &&
                     ((r_tot_vld && (w_line_total != r_line_total)) ||
                      (w_de_line && r_disp_vld && (r_decnt != r_line_disp)));
      w_t_htot     = w_hs_start ? w_line_total : r_line_total;
      w_t_hdisp    = (w_hs_start && w_de_line) ? r_decnt : r_line_disp;
      w_t_vtot     = (w_hs_start && (r_vcnt != CntMax)) ? r_vcnt + CntOne : r_vcnt;
      w_t_vdisp    = (w_hs_start && w_de_line && (r_actcnt != CntMax)) ?
                     r_actcnt + CntOne : r_actcnt;
      w_t_bad      = r_frame_bad | w_line_bad;
      w_ovf        = (!w_hs_start && (r_hcnt == CntMaxM1)) ||
                     (w_hs_start && !w_vs_start && (r_vcnt == CntMaxM1));
      w_match      = (w_t_htot == r_meas_htot) && (w_t_hdisp == r_meas_hdisp) &&
                     (w_t_vtot == r_meas_vtot) && (w_t_vdisp == r_meas_vdisp);
      w_cnt_inc    = r_match_cnt + 4'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hcnt       <= '0;
         r_decnt      <= '0;
         r_vcnt       <= '0;
         r_actcnt     <= '0;
         r_line_total <= '0;
         r_line_disp  <= '0;
         r_tot_vld    <= 1'b0;
         r_disp_vld   <= 1'b0;
         r_frame_bad  <= 1'b0;
      end else begin
         if (w_hs_start) begin
            r_hcnt       <= '0;
            r_decnt      <= r_de1 ? CntOne : '0;
            r_line_total <= w_line_total;
            r_tot_vld    <= 1'b1;
            if (w_de_line) begin
               r_line_disp <= r_decnt;
               r_disp_vld  <= 1'b1;
            end
         end else begin
            if (r_hcnt != CntMax) begin
               r_hcnt <= r_hcnt + CntOne;
            end
            if (r_de1 && (r_decnt != CntMax)) begin
               r_decnt <= r_decnt + CntOne;
            end
         end
         r_vcnt      <= w_t_vtot;
         r_actcnt    <= w_t_vdisp;
         r_frame_bad <= w_t_bad;
         if (w_vs_start) begin
            r_vcnt      <= '0;
            r_actcnt    <= '0;
            r_frame_bad <= 1'b0;
            r_tot_vld   <= 1'b0;
            r_disp_vld  <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= StSearch;
         r_match_cnt  <= '0;
         r_meas_htot  <= '0;
         r_meas_hdisp <= '0;
         r_meas_vtot  <= '0;
         r_meas_vdisp <= '0;
         r_locked     <= 1'b0;
         r_terr       <= 1'b0;
      end else begin
         r_terr <= 1'b0;
         if (w_ovf) begin
            r_state     <= StSearch;
            r_match_cnt <= '0;
            r_locked    <= 1'b0;
            r_terr      <= 1'b1;
         end else if (w_vs_start) begin
            unique case (r_state)
               StSearch: begin
                  r_state <= StMeasure;
               end
               StMeasure: begin
                  r_meas_htot  <= w_t_htot;
                  r_meas_hdisp <= w_t_hdisp;
                  r_meas_vtot  <= w_t_vtot;
                  r_meas_vdisp <= w_t_vdisp;
                  r_match_cnt  <= 4'd1;
                  if (LockCnt <= 4'd1) begin
                     r_state  <= StLocked;
                     r_locked <= 1'b1;
                  end else begin
                     r_state <= StVerify;
                  end
               end
               StVerify: begin
                  if (w_match && !w_t_bad) begin
                     r_match_cnt <= w_cnt_inc;
                     if (w_cnt_inc >= LockCnt) begin
                        r_state  <= StLocked;
                        r_locked <= 1'b1;
                     end
                  end else begin
                     r_meas_htot  <= w_t_htot;
                     r_meas_hdisp <= w_t_hdisp;
                     r_meas_vtot  <= w_t_vtot;
                     r_meas_vdisp <= w_t_vdisp;
                     r_match_cnt  <= 4'd1;
                     r_terr       <= 1'b1;
                  end
               end
               StLocked: begin
                  if (!w_match || w_t_bad) begin
                     r_meas_htot  <= w_t_htot;
                     r_meas_hdisp <= w_t_hdisp;
                     r_meas_vtot  <= w_t_vtot;
                     r_meas_vdisp <= w_t_vdisp;
                     r_match_cnt  <= 4'd1;
                     r_terr       <= 1'b1;
                     r_locked     <= 1'b0;
                     r_state      <= StVerify;
                  end
               end
               default: begin
                  r_state <= StSearch;
               end
            endcase
         end
      end
   end

   assign vid_if.pix_valid    = r_pix_valid;
   assign vid_if.pix_data     = r_pix_data;
   assign vid_if.pix_x        = r_pix_x;
   assign vid_if.pix_y        = r_pix_y;
   assign vid_if.sof          = r_sof;
   assign vid_if.eol          = r_eol;
   assign vid_if.meas_h_total = r_meas_htot;
   assign vid_if.meas_h_disp  = r_meas_hdisp;
   assign vid_if.meas_v_total = r_meas_vtot;
   assign vid_if.meas_v_disp  = r_meas_vdisp;
   assign vid_if.locked       = r_locked;
   assign vid_if.timing_err   = r_terr;

endmodule

// File: tb/tb_video_timing_rx.sv
// Directed bench for video_timing_rx: two receivers (active-low and active-high sync)
// fed from one scaled-down stream; lock, measurement, error and pixel-path checks.
module tb_video_timing_rx;

   typedef struct {
      int htot; int hs; int hbp; int hact;
      int vtot; int vs; int vbp; int vact;
   } tim_t;

   typedef struct packed {
      logic        de;
      logic [23:0] rgb;
      logic [7:0]  x;
      logic [7:0]  y;
   } pix_t;

   logic        clk;
   logic        rst_n;
   logic        g_hs, g_vs, g_de;
   logic [23:0] g_rgb;
   logic [7:0]  g_x, g_y;

   int total = 0;
   int bad   = 0;
   int pix_mism = 0;
   int n_sof = 0;
   int n_eol = 0;
   int n_err = 0;
   pix_t p1, p2;
   tim_t t_a, t_b;

   video_timing_rx_if #(.CNT_W(8)) vif_n ();
   video_timing_rx_if #(.CNT_W(8)) vif_p ();

   assign vif_n.vid_hs  = g_hs;
   assign vif_n.vid_vs  = g_vs;
   assign vif_n.vid_de  = g_de;
   assign vif_n.vid_rgb = g_rgb;
   assign vif_p.vid_hs  = ~g_hs;
   assign vif_p.vid_vs  = ~g_vs;
   assign vif_p.vid_de  = g_de;
   assign vif_p.vid_rgb = g_rgb;

   video_timing_rx #(.SYNC_POL(0), .LOCK_FRAMES(2), .CNT_W(8)) u_dut_n (
      .clk    (clk),
      .rst_n  (rst_n),
      .vid_if (vif_n)
   );

   video_timing_rx #(.SYNC_POL(1), .LOCK_FRAMES(2), .CNT_W(8)) u_dut_p (
      .clk    (clk),
      .rst_n  (rst_n),
      .vid_if (vif_p)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expected pixel outputs follow the stimulus by two clocks
   always @(negedge clk) begin
      if (!rst_n) begin
         p1 = '0;
         p2 = '0;
      end else begin
         if (vif_n.pix_valid !== p2.de ||
             vif_n.pix_data !== (p2.de ? p2.rgb : 24'h0) ||
             vif_n.pix_x !== (p2.de ? p2.x : 8'h0) ||
             vif_n.pix_y !== (p2.de ? p2.y : 8'h0) ||
             vif_n.sof !== (p2.de && p2.x == 8'h0 && p2.y == 8'h0) ||
             vif_n.eol !== (p2.de && !p1.de))
            pix_mism++;
         if (vif_n.sof === 1'b1) n_sof++;
         if (vif_n.eol === 1'b1) n_eol++;
         if (vif_n.timing_err === 1'b1) n_err++;
         p2 = p1;
         p1 = {g_de, g_rgb, g_x, g_y};
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_meas(input string tag, input int ht, input int hd, input int vt,
                           input int vd);
      chk({tag, "_n_h_total"}, 32'(vif_n.meas_h_total), ht);
      chk({tag, "_n_h_disp"},  32'(vif_n.meas_h_disp),  hd);
      chk({tag, "_n_v_total"}, 32'(vif_n.meas_v_total), vt);
      chk({tag, "_n_v_disp"},  32'(vif_n.meas_v_disp),  vd);
   endtask

   task automatic chk_meas_p(input string tag, input int ht, input int hd, input int vt,
                             input int vd);
      chk({tag, "_p_h_total"}, 32'(vif_p.meas_h_total), ht);
      chk({tag, "_p_h_disp"},  32'(vif_p.meas_h_disp),  hd);
      chk({tag, "_p_v_total"}, 32'(vif_p.meas_v_total), vt);
      chk({tag, "_p_v_disp"},  32'(vif_p.meas_v_disp),  vd);
   endtask

   task automatic idle();
      g_hs  = 1'b1;
      g_vs  = 1'b1;
      g_de  = 1'b0;
      g_rgb = '0;
      g_x   = '0;
      g_y   = '0;
   endtask

   task automatic send_line(input tim_t t, input int len, input bit vs_on, input bit act,
                            input int y);
      int hstart;
      hstart = t.hs + t.hbp;
      for (int c = 0; c < len; c++) begin
         @(posedge clk);
         #1;
         g_hs  = !(c < t.hs);
         g_vs  = !vs_on;
         g_de  = act && (c >= hstart) && (c < hstart + t.hact);
         g_x   = 8'(c - hstart);
         g_y   = 8'(y);
         g_rgb = 24'($urandom());
      end
   endtask

   task automatic send_frame(input tim_t t, input int long_row);
      int vstart;
      vstart = t.vs + t.vbp;
      for (int r = 0; r < t.vtot; r++) begin
         send_line(t, t.htot + ((r == long_row) ? 1 : 0), r < t.vs,
                   (r >= vstart) && (r < vstart + t.vact), r - vstart);
      end
   endtask

   initial begin
      t_a = '{20, 4, 3, 10, 11, 2, 2, 6};
      t_b = '{24, 4, 4, 14, 14, 2, 3, 8};
      idle();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pix_valid", 32'(vif_n.pix_valid), 0);
      chk("rst_locked", 32'(vif_n.locked), 0);
      chk("rst_h_total", 32'(vif_n.meas_h_total), 0);
      chk("rst_timing_err", 32'(vif_n.timing_err), 0);
      chk("rst_p_locked", 32'(vif_p.locked), 0);
      rst_n = 1'b1;

      // Timing A: 20/10 per line, 11/6 lines
      send_frame(t_a, -1);
      send_frame(t_a, -1);
      chk_meas("a_capture", 20, 10, 11, 6);
      chk("a_not_locked_2", 32'(vif_n.locked), 0);
      send_frame(t_a, -1);
      chk("a_locked_3", 32'(vif_n.locked), 1);
      chk("a_p_locked_3", 32'(vif_p.locked), 1);
      send_frame(t_a, -1);
      chk("a_locked_4", 32'(vif_n.locked), 1);
      chk("a_no_err", n_err, 0);
      chk("a_sof_count", n_sof, 4);
      chk("a_eol_count", n_eol, 24);
      chk_meas_p("a_pol", 20, 10, 11, 6);

      // Switch to timing B: 24/14 per line, 14/8 lines
      send_frame(t_b, -1);
      chk("b1_locked", 32'(vif_n.locked), 1);
      chk("b1_err", n_err, 0);
      send_frame(t_b, -1);
      chk("b2_err", n_err, 1);
      chk("b2_unlocked", 32'(vif_n.locked), 0);
      chk_meas("b2", 24, 14, 14, 8);
      send_frame(t_b, -1);
      chk("b3_relocked", 32'(vif_n.locked), 1);
      chk("b3_err", n_err, 1);

      // One long line mid-frame
      send_frame(t_b, 7);
      chk("long_still_locked", 32'(vif_n.locked), 1);
      send_frame(t_b, -1);
      chk("long_err", n_err, 2);
      chk("long_unlocked", 32'(vif_n.locked), 0);
      chk("long_h_total", 32'(vif_n.meas_h_total), 24);
      send_frame(t_b, -1);
      chk("long_relocked", 32'(vif_n.locked), 1);

      // vs held inactive until the line counter saturates
      for (int i = 0; i < 260; i++) send_line(t_b, t_b.htot, 1'b0, 1'b0, 0);
      chk("ovf_err_once", n_err, 3);
      chk("ovf_unlocked", 32'(vif_n.locked), 0);
      chk("ovf_keep_v_total", 32'(vif_n.meas_v_total), 14);
      chk("ovf_p_unlocked", 32'(vif_p.locked), 0);
      send_frame(t_b, -1);
      chk("resume1_unlocked", 32'(vif_n.locked), 0);
      send_frame(t_b, -1);
      chk("resume2_unlocked", 32'(vif_n.locked), 0);
      chk("resume2_err", n_err, 3);
      send_frame(t_b, -1);
      chk("resume3_locked", 32'(vif_n.locked), 1);

      // Reset in the middle of an active line
      for (int r = 0; r < 6; r++) send_line(t_b, t_b.htot, r < 2, r >= 5, r - 5);
      send_line(t_b, 12, 1'b0, 1'b1, 1);
      chk("pre_rst_locked", 32'(vif_n.locked), 1);
      rst_n = 1'b0;
      idle();
      #1;
      chk("midrst_pix_valid", 32'(vif_n.pix_valid), 0);
      chk("midrst_pix_x", 32'(vif_n.pix_x), 0);
      chk("midrst_pix_data", 32'(vif_n.pix_data), 0);
      chk("midrst_locked", 32'(vif_n.locked), 0);
      chk_meas("midrst", 0, 0, 0, 0);
      chk("midrst_p_h_total", 32'(vif_p.meas_h_total), 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      send_frame(t_b, -1);
      chk("d1_no_capture", 32'(vif_n.meas_h_total), 0);
      send_frame(t_b, -1);
      chk_meas("d2", 24, 14, 14, 8);
      chk("d2_unlocked", 32'(vif_n.locked), 0);
      send_frame(t_b, -1);
      chk("d3_locked", 32'(vif_n.locked), 1);
      chk_meas_p("d3_pol", 24, 14, 14, 8);
      chk("d3_p_locked", 32'(vif_p.locked), 1);
      chk("final_err", n_err, 3);
      chk("pixel_mismatches", pix_mism, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
